// File: rtl/aimc_lib_pkg.sv
// Shared AIMC definitions: command encoding, packet metadata and bank-arbiter defaults.
package aimc_lib;
    localparam int PRIO           = 4;
    localparam int PRIO_W         = $clog2(PRIO);
    localparam int BK_ADDR_WIDTH  = 4;
    localparam int ROW_ADDR_WIDTH = 14;

    localparam int BKARB_MASK_CYC     = 2;
    localparam int BKARB_STARVE_LIMIT = 8;

    typedef enum logic [2:0] {
        NOP1  = 3'd0,
        ACT   = 3'd1,
        RD    = 3'd2,
        WR    = 3'd3,
        PREPB = 3'd4,
        REFPB = 3'd5,
        NOP2  = 3'd6,
        MRS   = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        REQ_RD      = 2'd0,
        REQ_WR      = 2'd1,
        REQ_FLUSH   = 2'd2,
        REQ_REFRESH = 2'd3
    } req_type_t;

    typedef struct packed {
        logic [PRIO_W-1:0]         prio;
        logic [BK_ADDR_WIDTH-1:0]  bk_addr;
        logic [ROW_ADDR_WIDTH-1:0] row_addr;
        req_type_t                 req_type;
    } pkt_meta_t;
endpackage

// File: rtl/bank_cmd_arbiter_rr_prio_picker.sv
// Combinational winner selection: highest {starved, prio} key, ties to the first index at/after rr_ptr.
module rr_prio_picker
    import aimc_lib::*;
#(
    parameter int NUM_BKE = 16,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_BKE-1:0]             elig,
    input  logic [NUM_BKE-1:0][PRIO_W-1:0] prio,
    input  logic [IDX_W-1:0]               rr_ptr,
    input  logic [NUM_BKE-1:0]             starved,
    output logic [IDX_W-1:0]               win_idx,
    output logic                           found
);
    logic [PRIO_W:0] best_key;
    logic [PRIO_W:0] key;
    logic [IDX_W:0]  pos;

    // Walk in round-robin order; a strictly greater key is needed to displace an earlier candidate.
    always_comb begin
        win_idx  = '0;
        found    = 1'b0;
        best_key = '0;
        key      = '0;
        pos      = '0;
        for (int k = 0; k < NUM_BKE; k++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_BKE))
                pos = pos - (IDX_W+1)'(NUM_BKE);
            key = {starved[pos[IDX_W-1:0]], prio[pos[IDX_W-1:0]]};
            if (elig[pos[IDX_W-1:0]] && (!found || key > best_key)) begin
                found    = 1'b1;
                best_key = key;
                win_idx  = pos[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/bank_cmd_arbiter.sv
// Bank-engine command arbiter: priority + round-robin pick, registered ack/broadcast.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module bank_cmd_arbiter
    import aimc_lib::*;
#(
    parameter int NUM_BKE      = 16,
    parameter int MASK_CYC     = BKARB_MASK_CYC,
    parameter int STARVE_LIMIT = BKARB_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  pkt_meta_t [NUM_BKE-1:0]       bke_pkt,
    input  cmd_t      [NUM_BKE-1:0]       bke_cmd,
    input  logic      [NUM_BKE-1:0]       bke_pkt_req,
    output logic      [NUM_BKE-1:0]       bkarb_pkt_ack,
    output cmd_t                          bkarb_cmd,
    output logic      [BK_ADDR_WIDTH-1:0] bkarb_cmd_bk,
    output logic      [ROW_ADDR_WIDTH-1:0] bkarb_cmd_row,
    output logic                          bkarb_cmd_valid,
    output pkt_meta_t                     bkarb_pkt,
    input  logic                          phy_ready
);
    localparam int IDX_W  = (NUM_BKE > 1) ? $clog2(NUM_BKE) : 1;
    localparam int MASK_W = (MASK_CYC > 0) ? $clog2(MASK_CYC + 1) : 1;

    logic [IDX_W-1:0]               rr_ptr;
    logic [IDX_W-1:0]               win_idx;
    logic                           win_found;
    logic [NUM_BKE-1:0]             elig;
    logic [NUM_BKE-1:0]             starved;
    logic [NUM_BKE-1:0][PRIO_W-1:0] prio;
    logic [MASK_W-1:0]              mask_cnt [NUM_BKE];

    always_comb begin
        for (int i = 0; i < NUM_BKE; i++) begin
            prio[i] = bke_pkt[i].prio;
            elig[i] = bke_pkt_req[i] && (bke_cmd[i] != NOP1) && (mask_cnt[i] == '0) && phy_ready;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt [NUM_BKE];

    always_comb begin
        for (int i = 0; i < NUM_BKE; i++)
            starved[i] = (starve_cnt[i] >= STARVE_W'(STARVE_LIMIT));
    end

    // Counts consecutive eligible-but-lost cycles; any non-eligible cycle or a grant restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BKE; i++)
                starve_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BKE; i++) begin
                if (!elig[i] || (win_found && win_idx == IDX_W'(i)))
                    starve_cnt[i] <= '0;
                else if (starve_cnt[i] < STARVE_W'(STARVE_LIMIT))
                    starve_cnt[i] <= starve_cnt[i] + STARVE_W'(1);
            end
        end
    end
`else
    assign starved = '0;
`endif

    rr_prio_picker #(
        .NUM_BKE (NUM_BKE),
        .IDX_W   (IDX_W)
    ) u_picker (
        .elig    (elig),
        .prio    (prio),
        .rr_ptr  (rr_ptr),
        .starved (starved),
        .win_idx (win_idx),
        .found   (win_found)
    );

    // Issue register: data fields hold when nothing is granted, ack/valid pulse for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bkarb_pkt_ack   <= '0;
            bkarb_cmd       <= NOP1;
            bkarb_cmd_bk    <= '0;
            bkarb_cmd_row   <= '0;
            bkarb_cmd_valid <= 1'b0;
            bkarb_pkt       <= '0;
            rr_ptr          <= '0;
            for (int i = 0; i < NUM_BKE; i++)
                mask_cnt[i] <= '0;
        end else begin
            bkarb_pkt_ack   <= '0;
            bkarb_cmd_valid <= 1'b0;
            if (win_found) begin
                bkarb_pkt_ack   <= NUM_BKE'(1) << win_idx;
                bkarb_cmd       <= bke_cmd[win_idx];
                bkarb_cmd_bk    <= bke_pkt[win_idx].bk_addr;
                bkarb_cmd_row   <= bke_pkt[win_idx].row_addr;
                bkarb_cmd_valid <= 1'b1;
                bkarb_pkt       <= bke_pkt[win_idx];
                rr_ptr          <= (win_idx == IDX_W'(NUM_BKE - 1)) ? '0 : win_idx + IDX_W'(1);
            end
            // The mask hides the winner's still-registered request for MASK_CYC cycles.
            for (int i = 0; i < NUM_BKE; i++) begin
                if (win_found && win_idx == IDX_W'(i))
                    mask_cnt[i] <= MASK_W'(MASK_CYC);
                else if (mask_cnt[i] != '0)
                    mask_cnt[i] <= mask_cnt[i] - MASK_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: two instances (MASK_CYC=2 and MASK_CYC=0) against a rule-level model.
module tb_bank_cmd_arbiter;
    import aimc_lib::*;

    localparam int NB         = 16;
    localparam int STARVE_LIM = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    pkt_meta_t [NB-1:0]   pkt_in;
    cmd_t      [NB-1:0]   cmd_in;
    logic      [NB-1:0]   req;
    logic                 phy_ready;

    logic [NB-1:0]             ack_a, ack_b;
    cmd_t                      cmd_a, cmd_b;
    logic [BK_ADDR_WIDTH-1:0]  bk_a, bk_b;
    logic [ROW_ADDR_WIDTH-1:0] row_a, row_b;
    logic                      vld_a, vld_b;
    pkt_meta_t                 pkt_a, pkt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int                        m_mask   [2][NB];
    int                        m_starve [2][NB];
    int                        m_rr     [2];
    logic [NB-1:0]             e_ack    [2];
    logic                      e_vld    [2];
    cmd_t                      e_cmd    [2];
    logic [BK_ADDR_WIDTH-1:0]  e_bk     [2];
    logic [ROW_ADDR_WIDTH-1:0] e_row    [2];
    pkt_meta_t                 e_pkt    [2];

    always #5 clk = ~clk;

    bank_cmd_arbiter #(.NUM_BKE(NB), .MASK_CYC(2), .STARVE_LIMIT(STARVE_LIM)) dut_a (
        .clk(clk), .rst(rst), .bke_pkt(pkt_in), .bke_cmd(cmd_in), .bke_pkt_req(req),
        .bkarb_pkt_ack(ack_a), .bkarb_cmd(cmd_a), .bkarb_cmd_bk(bk_a), .bkarb_cmd_row(row_a),
        .bkarb_cmd_valid(vld_a), .bkarb_pkt(pkt_a), .phy_ready(phy_ready));

    bank_cmd_arbiter #(.NUM_BKE(NB), .MASK_CYC(0), .STARVE_LIMIT(STARVE_LIM)) dut_b (
        .clk(clk), .rst(rst), .bke_pkt(pkt_in), .bke_cmd(cmd_in), .bke_pkt_req(req),
        .bkarb_pkt_ack(ack_b), .bkarb_cmd(cmd_b), .bkarb_cmd_bk(bk_b), .bkarb_cmd_row(row_b),
        .bkarb_cmd_valid(vld_b), .bkarb_pkt(pkt_b), .phy_ready(phy_ready));

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rr[d]  = 0;
            e_ack[d] = '0;
            e_vld[d] = 1'b0;
            e_cmd[d] = NOP1;
            e_bk[d]  = '0;
            e_row[d] = '0;
            e_pkt[d] = '0;
            for (int i = 0; i < NB; i++) begin
                m_mask[d][i]   = 0;
                m_starve[d][i] = 0;
            end
        end
    endtask

    // Pick by rule: starved engines first (if the guard exists), else the top prio; ties in rr order.
    task automatic model_step(input int d, input int mcyc);
        bit el  [NB];
        bit stv [NB];
        bit any_stv;
        int best;
        int w;
        int idx;
        any_stv = 1'b0;
        best    = -1;
        w       = -1;
        for (int i = 0; i < NB; i++) begin
            el[i] = req[i] && (cmd_in[i] != NOP1) && (m_mask[d][i] == 0) && phy_ready;
`ifdef ARB_STARVE_GUARD_EN
            stv[i] = el[i] && (m_starve[d][i] >= STARVE_LIM);
`else
            stv[i] = 1'b0;
`endif
            if (stv[i]) any_stv = 1'b1;
            if (el[i] && int'(pkt_in[i].prio) > best) best = int'(pkt_in[i].prio);
        end
        for (int k = 0; k < NB && w < 0; k++) begin
            idx = (m_rr[d] + k) % NB;
            if (any_stv ? stv[idx] : (el[idx] && int'(pkt_in[idx].prio) == best)) w = idx;
        end
        e_ack[d] = '0;
        e_vld[d] = 1'b0;
        if (w >= 0) begin
            e_ack[d][w] = 1'b1;
            e_vld[d]    = 1'b1;
            e_cmd[d]    = cmd_in[w];
            e_bk[d]     = pkt_in[w].bk_addr;
            e_row[d]    = pkt_in[w].row_addr;
            e_pkt[d]    = pkt_in[w];
            m_rr[d]     = (w + 1) % NB;
        end
        for (int i = 0; i < NB; i++) begin
            if (el[i] && i != w)
                m_starve[d][i] = (m_starve[d][i] + 1 > STARVE_LIM) ? STARVE_LIM : m_starve[d][i] + 1;
            else
                m_starve[d][i] = 0;
            if (i == w) m_mask[d][i] = mcyc;
            else if (m_mask[d][i] > 0) m_mask[d][i] = m_mask[d][i] - 1;
        end
    endtask

    task automatic step();
        model_step(0, 2);
        model_step(1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req       = '0;
        phy_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            cmd_in[i] = NOP1;
            pkt_in[i] = '0;
        end
    endtask

    task automatic set_eng(input int i, input cmd_t c, input int p, input int b, input int r);
        cmd_in[i]          = c;
        pkt_in[i].prio     = PRIO_W'(p);
        pkt_in[i].bk_addr  = BK_ADDR_WIDTH'(b);
        pkt_in[i].row_addr = ROW_ADDR_WIDTH'(r);
        pkt_in[i].req_type = (c == REFPB) ? REQ_REFRESH : REQ_RD;
        req[i]             = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (ack_a !== '0 || vld_a !== 1'b0 || cmd_a !== NOP1 || bk_a !== '0 || row_a !== '0 || pkt_a !== '0)
            $display("FAIL reset_a: ack=%h vld=%b cmd=%0d bk=%h row=%h required all zero/NOP1", ack_a, vld_a, cmd_a, bk_a, row_a);
        else pass_cnt++;
        total_cnt++;
        if (ack_b !== '0 || vld_b !== 1'b0 || cmd_b !== NOP1 || pkt_b !== '0)
            $display("FAIL reset_b: ack=%h vld=%b cmd=%0d required all zero/NOP1", ack_b, vld_b, cmd_b);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NB-1:0] exp_seq [4];
        exp_seq = '{16'h0008, 16'h0000, 16'h0000, 16'h0008};
        clear_inputs();
        set_eng(3, ACT, 1, 3, 'h1A5);
        for (int c = 0; c < 4; c++) begin
            step();
            total_cnt++;
            if (ack_a !== exp_seq[c] || vld_a !== exp_seq[c][3])
                $display("FAIL single_ack_c%0d: ack=%h vld=%b required ack=%h", c + 1, ack_a, vld_a, exp_seq[c]);
            else pass_cnt++;
        end
        total_cnt++;
        if (cmd_a !== ACT || bk_a !== 4'd3 || row_a !== 14'h1A5)
            $display("FAIL single_fields: cmd=%0d bk=%h row=%h required cmd=1 bk=3 row=1a5", cmd_a, bk_a, row_a);
        else pass_cnt++;
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_priority();
        clear_inputs();
        set_eng(2, RD, 1, 2, 'h22);
        set_eng(9, REFPB, PRIO - 1, 9, 0);
        step();
        total_cnt++;
        if (ack_a !== 16'h0200 || cmd_a !== REFPB || bk_a !== 4'd9)
            $display("FAIL prio_first: ack=%h cmd=%0d bk=%h required ack=0200 cmd=5 bk=9", ack_a, cmd_a, bk_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ack_a !== 16'h0004 || cmd_a !== RD || row_a !== 14'h22)
            $display("FAIL prio_second: ack=%h cmd=%0d row=%h required ack=0004 cmd=2 row=22", ack_a, cmd_a, row_a);
        else pass_cnt++;
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_round_robin();
        int order [4];
        order = '{15, 0, 5, 15};
        clear_inputs();
        set_eng(5, WR, 1, 5, 5);
        step();
        total_cnt++;
        if (ack_b !== 16'h0020)
            $display("FAIL rr_setup: ack=%h required 0020", ack_b);
        else pass_cnt++;
        set_eng(0, WR, 1, 0, 0);
        set_eng(15, WR, 1, 15, 15);
        for (int c = 0; c < 4; c++) begin
            step();
            total_cnt++;
            if (ack_b !== (16'h0001 << order[c]))
                $display("FAIL rr_order_%0d: ack=%h required engine %0d", c, ack_b, order[c]);
            else pass_cnt++;
        end
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        set_eng(7, RD, 1, 7, 'h55);
        phy_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt++;
            if (ack_a !== '0 || vld_a !== 1'b0 || ack_b !== '0 || vld_b !== 1'b0 ||
                cmd_a !== e_cmd[0] || bk_a !== e_bk[0] || row_a !== e_row[0] || pkt_a !== e_pkt[0])
                $display("FAIL bp_hold_%0d: ack=%h vld=%b cmd=%0d row=%h required no ack, cmd=%0d row=%h",
                         c, ack_a, vld_a, cmd_a, row_a, e_cmd[0], e_row[0]);
            else pass_cnt++;
        end
        phy_ready = 1'b1;
        step();
        total_cnt++;
        if (ack_a !== 16'h0080 || vld_a !== 1'b1 || ack_b !== 16'h0080 || row_a !== 14'h55)
            $display("FAIL bp_release: ack_a=%h ack_b=%h row=%h required 0080 and row 55", ack_a, ack_b, row_a);
        else pass_cnt++;
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_eng(4, WR, 1, 4, 'h10);
        step();
        total_cnt++;
        if (ack_a !== 16'h0010)
            $display("FAIL rstmid_pre: ack=%h required 0010", ack_a);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ack_a !== '0 || cmd_a !== NOP1 || vld_a !== 1'b0 || ack_b !== '0 || vld_b !== 1'b0)
            $display("FAIL rstmid_async: ack=%h cmd=%0d vld=%b required 0/NOP1/0", ack_a, cmd_a, vld_a);
        else pass_cnt++;
        model_reset();
        set_eng(1, WR, 1, 1, 1);
        set_eng(10, WR, 1, 10, 10);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        total_cnt++;
        if (ack_a !== 16'h0002 || ack_b !== 16'h0002)
            $display("FAIL rstmid_first: ack_a=%h ack_b=%h required 0002", ack_a, ack_b);
        else pass_cnt++;
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_starve();
        int granted_at;
        int required;
`ifdef ARB_STARVE_GUARD_EN
        required = 9;
`else
        required = -1;
`endif
        granted_at = -1;
        clear_inputs();
        set_eng(1, RD, 0, 1, 1);
        set_eng(2, WR, 2, 2, 2);
        set_eng(3, WR, 2, 3, 3);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ack_b[1] === 1'b1 && granted_at < 0) granted_at = c;
            total_cnt++;
            if (ack_a !== e_ack[0] || ack_b !== e_ack[1] || cmd_b !== e_cmd[1])
                $display("FAIL starve_model_%0d: ack_a=%h ack_b=%h required %h %h", c, ack_a, ack_b, e_ack[0], e_ack[1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (granted_at != required)
            $display("FAIL starve_grant: engine 1 first acked at step %0d required %0d", granted_at, required);
        else pass_cnt++;
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NB; i++) begin
                req[i]             = ($urandom_range(0, 1) == 1);
                cmd_in[i]          = cmd_t'(3'($urandom_range(0, 7)));
                pkt_in[i].prio     = PRIO_W'($urandom_range(0, PRIO - 1));
                pkt_in[i].bk_addr  = BK_ADDR_WIDTH'($urandom);
                pkt_in[i].row_addr = ROW_ADDR_WIDTH'($urandom);
                pkt_in[i].req_type = req_type_t'(2'($urandom_range(0, 3)));
            end
            phy_ready = ($urandom_range(0, 9) != 0);
            step();
            total_cnt++;
            if (ack_a !== e_ack[0] || vld_a !== e_vld[0] || cmd_a !== e_cmd[0] || bk_a !== e_bk[0] ||
                row_a !== e_row[0] || pkt_a !== e_pkt[0])
                $display("FAIL rand_a_%0d: ack=%h vld=%b cmd=%0d bk=%h row=%h required ack=%h vld=%b cmd=%0d bk=%h row=%h",
                         c, ack_a, vld_a, cmd_a, bk_a, row_a, e_ack[0], e_vld[0], e_cmd[0], e_bk[0], e_row[0]);
            else pass_cnt++;
            total_cnt++;
            if (ack_b !== e_ack[1] || vld_b !== e_vld[1] || cmd_b !== e_cmd[1] || bk_b !== e_bk[1] ||
                row_b !== e_row[1] || pkt_b !== e_pkt[1])
                $display("FAIL rand_b_%0d: ack=%h vld=%b cmd=%0d bk=%h row=%h required ack=%h vld=%b cmd=%0d bk=%h row=%h",
                         c, ack_b, vld_b, cmd_b, bk_b, row_b, e_ack[1], e_vld[1], e_cmd[1], e_bk[1], e_row[1]);
            else pass_cnt++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_starve();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
